// File: rtl/xsw_pkt_lock_mux_if.sv
// -----------------------------------------------------------------------------
// xsw_pkt_lock_mux_if
//   Bundle for the packet lock mux. It groups the initiator-side beat bus, the
//   target-side beat bus and the arbiter request/grant wires.
//   slave  : the lock mux itself.
//   master : the environment around it (initiators, target, arbiter).
// Signals
//   in_valid/in_last/in_data/in_ready   per-initiator beat bus (data i at [i*DW +: DW])
//   out_valid/out_last/out_data/out_src target beat bus plus the locked source index
//   out_ready                           target ready
//   arb_en/arb_req/arb_gnt              arbiter enable, requests, one-hot grant
//   busy                                lock held
// -----------------------------------------------------------------------------
interface xsw_pkt_lock_mux_if #(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int SW = (N > 1) ? $clog2(N) : 1
);
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_last;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic            out_last;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;
   logic            out_ready;
   logic            arb_en;
   logic [N-1:0]    arb_req;
   logic [N-1:0]    arb_gnt;
   logic            busy;

   modport slave (
      input  in_valid, in_last, in_data, out_ready, arb_gnt,
      output in_ready, out_valid, out_last, out_data, out_src, arb_en, arb_req, busy
   );

   modport master (
      output in_valid, in_last, in_data, out_ready, arb_gnt,
      input  in_ready, out_valid, out_last, out_data, out_src, arb_en, arb_req, busy
   );
endinterface

// File: rtl/xsw_pkt_lock_mux.sv
// -----------------------------------------------------------------------------
// xsw_pkt_lock_mux
//   Packet-level initiator selector behind a round-robin arbiter. In IDLE it
//   presents the valid initiators to the arbiter for one cycle, captures the
//   one-hot grant and locks onto that initiator until its last beat has been
//   accepted by the target. While locked, the selected initiator's beat bus is
//   muxed to the target and the target's ready is routed back to it only.
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   bus          xsw_pkt_lock_mux_if.slave (initiator, target and arbiter wires)
//   timeout_err  one-cycle pulse when a locked packet stalls too long
//                (present only with XSW_LOCK_TIMEOUT_EN)
// Build option
//   XSW_LOCK_TIMEOUT_EN  adds the stall watchdog; TO_CYCLES sets its limit.
//                        Without it the lock is held indefinitely.
// -----------------------------------------------------------------------------
module xsw_pkt_lock_mux #(
   parameter int N         = 4,
   parameter int DW        = 32,
   parameter int SW        = (N > 1) ? $clog2(N) : 1,
   parameter int TO_CYCLES = 256
) (
   input  logic                clk,
   input  logic                rstn,
   xsw_pkt_lock_mux_if.slave   bus
`ifdef XSW_LOCK_TIMEOUT_EN
   ,
   output logic                timeout_err
`endif
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   sel_q, sel_d;
   logic [SW-1:0]  src_q, src_d;
   logic [SW-1:0]  gnt_idx;
   logic           mux_valid;
   logic           mux_last;
   logic [DW-1:0]  mux_data;
   logic           to_hit;

   // Grant is one-hot, so OR-ing the indices of set bits yields its binary index.
   always_comb begin : p_enc
      gnt_idx = '0;
      for (int i = 0; i < N; i++)
         if (bus.arb_gnt[i]) gnt_idx = gnt_idx | SW'(i);
   end

   // AND-OR mux on the locked one-hot select.
   always_comb begin : p_mux
      mux_valid = 1'b0;
      mux_last  = 1'b0;
      mux_data  = '0;
      for (int i = 0; i < N; i++) begin
         mux_valid = mux_valid | (bus.in_valid[i] & sel_q[i]);
         mux_last  = mux_last  | (bus.in_last[i]  & sel_q[i]);
         mux_data  = mux_data  | (bus.in_data[i*DW +: DW] & {DW{sel_q[i]}});
      end
   end

`ifdef XSW_LOCK_TIMEOUT_EN
   localparam int            CW      = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          xfer;

   assign to_hit      = (state_q == LOCK) && (cnt_q == TO_LAST);
   assign timeout_err = to_hit;
   assign xfer        = bus.out_valid & bus.out_ready;
   // Count consecutive stalled LOCK cycles; the firing cycle itself leaves LOCK.
   assign cnt_d       = ((state_q == LOCK) && !xfer && !to_hit) ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk or negedge rstn) begin : p_cnt
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin : p_fsm
      state_d       = state_q;
      sel_d         = sel_q;
      src_d         = src_q;
      bus.arb_en    = 1'b0;
      bus.arb_req   = '0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = '0;
      bus.in_ready  = '0;
      case (state_q)
         IDLE: begin
            // Gated by rstn so the arbiter sees nothing while reset is held.
            bus.arb_req = {N{rstn}} & bus.in_valid;
            bus.arb_en  = |bus.arb_req;
            if (bus.arb_en) begin
               sel_d   = bus.arb_gnt;
               src_d   = gnt_idx;
               state_d = LOCK;
            end
         end
         LOCK: begin
            bus.busy     = 1'b1;
            bus.out_last = mux_last;
            bus.out_data = mux_data;
            if (to_hit) begin
               // Watchdog cycle: nothing is forwarded, lock is dropped.
               state_d = IDLE;
               sel_d   = '0;
            end else begin
               bus.out_valid = mux_valid;
               bus.in_ready  = sel_q & {N{bus.out_ready}};
               if (mux_valid && bus.out_ready && mux_last) begin
                  state_d = IDLE;
                  sel_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin : p_state
      if (!rstn) begin
         state_q <= IDLE;
         sel_q   <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         src_q   <= src_d;
      end
   end

   // Source index survives the return to IDLE until the next grant.
   assign bus.out_src = src_q;

`ifndef SYNTHESIS
   localparam bit CFG_OK = (N >= 2) && (TO_CYCLES >= 2);

   a_cfg: assert property (@(posedge clk) CFG_OK);

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn)
      (bus.arb_en && (|bus.arb_req)) |-> $onehot(bus.arb_gnt));

   a_gnt_subset: assert property (@(posedge clk) disable iff (!rstn)
      ((bus.arb_gnt & ~bus.arb_req) == '0));

   a_sel_onehot: assert property (@(posedge clk) disable iff (!rstn)
      (state_q == LOCK) |-> $onehot(sel_q));
`endif

endmodule

// File: tb/tb_xsw_pkt_lock_mux.sv
// -----------------------------------------------------------------------------
// tb_xsw_pkt_lock_mux
//   Directed bench for xsw_pkt_lock_mux with a small round-robin arbiter model.
//   Each cycle the observable outputs are packed as
//   {arb_en, arb_req, busy, out_valid, out_last, in_ready, out_src, out_data}
//   and compared with hand-written per-cycle vectors.
// -----------------------------------------------------------------------------
module tb_xsw_pkt_lock_mux;
   localparam int N  = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   xsw_pkt_lock_mux_if #(.N(N), .DW(DW)) bus ();

`ifdef XSW_LOCK_TIMEOUT_EN
   logic timeout_err;
`endif

   xsw_pkt_lock_mux #(.N(N), .DW(DW), .TO_CYCLES(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
`ifdef XSW_LOCK_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   // Round-robin arbiter: first request at or after the pointer wins;
   // the pointer moves past the winner only when en is asserted.
   logic [1:0] ptr_q;
   always_comb begin
      logic [N-1:0] g;
      logic [1:0]   j;
      g = '0;
      j = '0;
      for (int k = 0; k < N; k++) begin
         j = ptr_q + 2'(k);
         if (g == '0 && bus.arb_req[j]) g[j] = 1'b1;
      end
      bus.arb_gnt = g;
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ptr_q <= '0;
      else if (bus.arb_en)
         for (int k = 0; k < N; k++)
            if (bus.arb_gnt[k]) ptr_q <= 2'(k + 1);
   end

   int n_tests = 0;
   int n_fail  = 0;
   int beat [N];

   logic [45:0] obs;
   assign obs = {bus.arb_en, bus.arb_req, bus.busy, bus.out_valid, bus.out_last,
                 bus.in_ready, bus.out_src, bus.out_data};

   function automatic logic [31:0] dat(input int i, input int b);
      return 32'hA000_0000 | 32'(i << 8) | 32'(b);
   endfunction

   function automatic logic [45:0] mk(input logic en, input logic [3:0] req, input logic bsy,
                                      input logic ov, input logic ol, input logic [3:0] rdy,
                                      input logic [1:0] src, input logic [31:0] d);
      return {en, req, bsy, ov, ol, rdy, src, d};
   endfunction

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
      bus.in_valid  = v;
      bus.in_last   = l;
      bus.out_ready = r;
      for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = dat(i, beat[i]);
   endtask

   // Called at the negedge after checking: account accepted beats, move to next cycle.
   task automatic next_cycle;
      for (int i = 0; i < N; i++)
         if (bus.in_valid[i] && bus.in_ready[i]) beat[i]++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rstn = 1'b0;
      for (int i = 0; i < N; i++) beat[i] = 0;
      drive(4'b0, 4'b0, 1'b0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_reset;
      logic [3:0] rv, rl;
      rstn = 1'b0;
      for (int i = 0; i < N; i++) beat[i] = 0;
      for (int c = 0; c < 3; c++) begin
         rv = 4'($urandom);
         rl = 4'($urandom);
         drive(rv, rl, 1'($urandom));
         for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = $urandom;
         @(negedge clk);
         n_tests++;
         if (obs !== 46'b0) begin
            n_fail++;
            $display("FAIL reset_hold c%0d: got %h want %h", c, obs, 46'b0);
         end
         @(posedge clk);
         #1;
      end
      drive(4'b0, 4'b0, 1'b1);
      rstn = 1'b1;
      @(negedge clk);
      n_tests++;
      if (obs !== 46'b0) begin
         n_fail++;
         $display("FAIL reset_release: got %h want %h", obs, 46'b0);
      end
      next_cycle();
      drive(4'b0100, 4'b0, 1'b1);
      @(negedge clk);
      n_tests++;
      if (obs !== mk(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0, 2'd0, 32'd0)) begin
         n_fail++;
         $display("FAIL reset_first_req: got %h want %h", obs,
                  mk(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0, 2'd0, 32'd0));
      end
      next_cycle();
      drive(4'b0100, 4'b0, 1'b1);
      @(negedge clk);
      n_tests++;
      if (obs !== mk(1'b0, 4'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, dat(2, 0))) begin
         n_fail++;
         $display("FAIL reset_pre_lock: got %h want %h", obs,
                  mk(1'b0, 4'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, dat(2, 0)));
      end
      // Asynchronous reset in the middle of a packet drops the lock at once.
      #1 rstn = 1'b0;
      #1;
      n_tests++;
      if (obs !== 46'b0) begin
         n_fail++;
         $display("FAIL reset_midpkt: got %h want %h", obs, 46'b0);
      end
      @(posedge clk);
      #1;
      do_reset();
   endtask

   task automatic test_single;
      logic [3:0]  tv [5];
      logic [3:0]  tl [5];
      logic [45:0] ex [5];
      tv = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
      tl = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
      ex = '{mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 32'd0),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, dat(1, 0)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, dat(1, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, dat(1, 2)),
             mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 32'd0)};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(tv[c], tl[c], 1'b1);
         @(negedge clk);
         n_tests++;
         if (obs !== ex[c]) begin
            n_fail++;
            $display("FAIL single c%0d: got %h want %h", c, obs, ex[c]);
         end
         next_cycle();
      end
   endtask

   // All four initiators hold a 2-beat packet: grant, beat0, beat1 per initiator
   // in rotation order 0,1,2,3, then idle with out_src left at 3.
   task automatic test_contention;
      logic [3:0]  v, l;
      logic [45:0] e;
      int          k, ph;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         for (int i = 0; i < N; i++) begin
            v[i] = (beat[i] < 2);
            l[i] = (beat[i] == 1);
         end
         drive(v, l, 1'b1);
         k  = c / 3;
         ph = c % 3;
         if (c == 12)
            e = mk(1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 2'd3, 32'd0);
         else if (ph == 0)
            e = mk(1'b1, 4'((4'hF << k) & 4'hF), 1'b0, 1'b0, 1'b0, 4'b0,
                   (k == 0) ? 2'd0 : 2'(k - 1), 32'd0);
         else
            e = mk(1'b0, 4'b0, 1'b1, 1'b1, (ph == 2), 4'(1 << k), 2'(k), dat(k, ph - 1));
         @(negedge clk);
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL contention c%0d: got %h want %h", c, obs, e);
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure;
      logic [3:0]  tv [12];
      logic [3:0]  tl [12];
      logic [0:11] tr;
      logic [45:0] ex [12];
      tv = '{4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
             4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0000};
      tl = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
             4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
      tr = 12'b1100_0001_1111;
      ex = '{mk(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 32'd0),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, dat(0, 0)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, dat(0, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, dat(0, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, dat(0, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, dat(0, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, dat(0, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, dat(0, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, dat(0, 2)),
             mk(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 32'd0),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, dat(2, 0)),
             mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 32'd0)};
      do_reset();
      for (int c = 0; c < 12; c++) begin
         drive(tv[c], tl[c], tr[c]);
         @(negedge clk);
         n_tests++;
         if (obs !== ex[c]) begin
            n_fail++;
            $display("FAIL backpressure c%0d: got %h want %h", c, obs, ex[c]);
         end
         next_cycle();
      end
   endtask

   task automatic test_gap;
      logic [3:0]  tv [10];
      logic [3:0]  tl [10];
      logic [45:0] ex [10];
      tv = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000,
             4'b0010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
      tl = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
             4'b0000, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
      ex = '{mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 32'd0),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, dat(1, 0)),
             mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd1, dat(1, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd1, dat(1, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd1, dat(1, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, dat(1, 1)),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0010, 2'd1, dat(1, 2)),
             mk(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 32'd0),
             mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, dat(3, 0)),
             mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 32'd0)};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive(tv[c], tl[c], 1'b1);
         @(negedge clk);
         n_tests++;
         if (obs !== ex[c]) begin
            n_fail++;
            $display("FAIL gap c%0d: got %h want %h", c, obs, ex[c]);
         end
         next_cycle();
      end
   endtask

`ifdef XSW_LOCK_TIMEOUT_EN
   // TO_CYCLES=8: grant in c0, stalls in c1..c8, watchdog fires on c8, re-arbitration in c9.
   task automatic test_timeout;
      logic [45:0] e;
      logic        te;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive(4'b0001, 4'b0000, (c == 0));
         if (c == 0 || c == 9)
            e = mk(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0, 2'd0, 32'd0);
         else if (c == 8)
            e = mk(1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 4'b0, 2'd0, dat(0, 0));
         else
            e = mk(1'b0, 4'b0, 1'b1, 1'b1, 1'b0, 4'b0, 2'd0, dat(0, 0));
         te = (c == 8);
         @(negedge clk);
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL timeout_bus c%0d: got %h want %h", c, obs, e);
         end
         n_tests++;
         if (timeout_err !== te) begin
            n_fail++;
            $display("FAIL timeout_err c%0d: got %b want %b", c, timeout_err, te);
         end
         next_cycle();
      end
   endtask
`endif

   initial begin
      rstn = 1'b0;
      for (int i = 0; i < N; i++) beat[i] = 0;
      drive(4'b0, 4'b0, 1'b0);
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_gap();
`ifdef XSW_LOCK_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
